// File: rtl/instruction_fetch_pkg.sv
// Shared definitions for the instruction fetch slice.
// Holds the FSM state encoding, the default reset PC, the syscall opcode and the IF/ID payload type.
`ifndef INSTRUCTION_FETCH_PKG_SV
`define INSTRUCTION_FETCH_PKG_SV
package instruction_fetch_pkg;

   localparam int unsigned XLEN = 32;

   localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
   localparam logic [XLEN-1:0] SYSCALL_OPCODE   = 32'h0000_000C;

   typedef enum logic [1:0] {
      ST_BOOT = 2'd0,
      ST_RUN  = 2'd1,
      ST_HALT = 2'd2
   } fetch_state_e;

   // IF/ID pipeline register payload
   typedef struct packed {
      logic [XLEN-1:0] instruction;
      logic [XLEN-1:0] pc_plus4;
   } if_id_t;

endpackage
`endif

// File: rtl/instruction_fetch_if.sv
// Instruction-memory bus between the fetch unit and a combinational memory.
//   imem_address : word address driven by fetch (master)
//   imem_data    : instruction word returned in the same cycle (slave)
interface instruction_fetch_if #(
   parameter int unsigned SIZE_EXP2 = 10
);
   logic [SIZE_EXP2-1:0] imem_address;
   logic [31:0]          imem_data;

   modport master (output imem_address, input imem_data);
   modport slave  (input imem_address, output imem_data);
endinterface

// File: rtl/instruction_fetch_pc.sv
// Program counter register with next-PC mux.
//   clk, rst_n          : clock, async active-low reset
//   advance_i           : sequential fetch, pc <= pc + 4
//   redirect_i          : load word-aligned redirect_target_i (wins over advance_i)
//   pc_o                : registered fetch byte address
//   pc_plus4_c_o        : combinational pc + 4
module program_counter
   import instruction_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        advance_i,
   input  logic        redirect_i,
   input  logic [31:0] redirect_target_i,
   output logic [31:0] pc_o,
   output logic [31:0] pc_plus4_c_o
);

   logic [31:0] pc_q;
   logic [31:0] pc_d;

   assign pc_plus4_c_o = pc_q + 32'd4;
   assign pc_o         = pc_q;

   // Low two target bits are dropped so the PC always stays word aligned
   always_comb begin
      pc_d = pc_q;
      if (redirect_i) begin
         pc_d = {redirect_target_i[31:2], 2'b00};
      end else if (advance_i) begin
         pc_d = pc_plus4_c_o;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q <= RESET_PC;
      end else begin
         pc_q <= pc_d;
      end
   end

endmodule

// File: rtl/instruction_fetch.sv
// Single-cycle instruction fetch stage with IF/ID register, BOOT/RUN/HALT control and fetch counter.
//   system_clock, system_reset_n : clock, async active-low reset
//   stall                        : decode cannot accept, hold PC and IF/ID
//   redirect_valid/target        : taken branch/jump, flushes IF/ID
//   imem                         : combinational instruction-memory bus
//   if_id_*                      : IF/ID register contents
//   pc, halted, misaligned, fetch_count : status
module instruction_fetch
   import instruction_fetch_pkg::*;
#(
   parameter int unsigned SIZE_EXP2 = 10,
   parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC
) (
   input  logic                system_clock,
   input  logic                system_reset_n,
   input  logic                stall,
   input  logic                redirect_valid,
   input  logic [31:0]         redirect_target,
   instruction_fetch_if.master imem,
   output logic                if_id_valid,
   output logic [31:0]         if_id_instruction,
   output logic [31:0]         if_id_pc_plus4,
   output logic [31:0]         pc,
   output logic                halted,
   output logic                misaligned,
   output logic [31:0]         fetch_count
);

   fetch_state_e state_q, state_d;
   logic         do_fetch_c;
   logic         do_redirect_c;
   logic         drop_valid_c;
   logic [31:0]  pc_plus4_c;

   if_id_t       if_id_q, if_id_d;
   logic         valid_q, valid_d;
   logic [31:0]  count_q, count_d;
   logic         mis_q, mis_d;
   logic         halted_q, halted_d;

   program_counter #(
      .RESET_PC (RESET_PC)
   ) u_pc (
      .clk               (system_clock),
      .rst_n             (system_reset_n),
      .advance_i         (do_fetch_c),
      .redirect_i        (do_redirect_c),
      .redirect_target_i (redirect_target),
      .pc_o              (pc),
      .pc_plus4_c_o      (pc_plus4_c)
   );

   // Memory is word addressed; upper PC bits alias (wrap modulo memory size)
   assign imem.imem_address = pc[SIZE_EXP2+1:2];

   // State register
   always_ff @(posedge system_clock or negedge system_reset_n) begin
      if (!system_reset_n) begin
         state_q <= ST_BOOT;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state: a syscall halts only when it is actually written into IF/ID
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_BOOT: state_d = ST_RUN;
         ST_RUN: begin
            if (!redirect_valid && !stall && (imem.imem_data == SYSCALL_OPCODE)) begin
               state_d = ST_HALT;
            end
         end
         ST_HALT: state_d = ST_HALT;
         default: state_d = ST_BOOT;
      endcase
   end

   // Control outputs: redirect beats stall in RUN; HALT only drains IF/ID
   always_comb begin
      do_fetch_c    = 1'b0;
      do_redirect_c = 1'b0;
      drop_valid_c  = 1'b0;
      case (state_q)
         ST_RUN: begin
            if (redirect_valid) begin
               do_redirect_c = 1'b1;
            end else if (!stall) begin
               do_fetch_c = 1'b1;
            end
         end
         ST_HALT: drop_valid_c = !stall;
         default: ;
      endcase
   end

   // IF/ID, counter and status next values
   always_comb begin
      if_id_d  = if_id_q;
      valid_d  = valid_q;
      count_d  = count_q;
      mis_d    = mis_q;
      halted_d = (state_d == ST_HALT);
      if (do_fetch_c) begin
         if_id_d.instruction = imem.imem_data;
         if_id_d.pc_plus4    = pc_plus4_c;
         valid_d             = 1'b1;
         count_d             = count_q + 32'd1;
      end
      if (do_redirect_c) begin
         valid_d = 1'b0;
         mis_d   = mis_q | (|redirect_target[1:0]);
      end
      if (drop_valid_c) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge system_clock or negedge system_reset_n) begin
      if (!system_reset_n) begin
         if_id_q  <= '0;
         valid_q  <= 1'b0;
         count_q  <= 32'd0;
         mis_q    <= 1'b0;
         halted_q <= 1'b0;
      end else begin
         if_id_q  <= if_id_d;
         valid_q  <= valid_d;
         count_q  <= count_d;
         mis_q    <= mis_d;
         halted_q <= halted_d;
      end
   end

   assign if_id_valid       = valid_q;
   assign if_id_instruction = if_id_q.instruction;
   assign if_id_pc_plus4    = if_id_q.pc_plus4;
   assign fetch_count       = count_q;
   assign misaligned        = mis_q;
   assign halted            = halted_q;

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 The module SHALL have parameter SIZE_EXP2, default 10, giving the instruction-memory word-address width.
REQ-002 The module SHALL have parameter RESET_PC, default 32'h0000_0000, giving the byte address of the first fetch.
REQ-003 system_clock  in  1  single clock; all state updates on its rising edge.
REQ-004 system_reset_n  in  1  reset, asynchronous assert, active-low.
REQ-005 stall  in  1  decode stage cannot accept; hold PC and the IF/ID register.
REQ-006 redirect_valid  in  1  branch or jump resolved taken this cycle.
REQ-007 redirect_target  in  32  byte address of the redirect.
REQ-008 imem_address  out  SIZE_EXP2  word address to the combinational instruction memory.
REQ-009 imem_data  in  32  instruction word returned in the same cycle.
REQ-010 if_id_valid  out  1  IF/ID register holds a real instruction.
REQ-011 if_id_instruction  out  32  registered instruction.
REQ-012 if_id_pc_plus4  out  32  registered byte address of the instruction plus 4.
REQ-013 pc  out  32  current fetch byte address.
REQ-014 halted  out  1  fetch stopped by a halt instruction.
REQ-015 misaligned  out  1  sticky flag: a redirect target had bits [1:0] not equal to 00.
REQ-016 fetch_count  out  32  count of instructions written into IF/ID.

Function
REQ-017 imem_address SHALL be combinationally pc[SIZE_EXP2+1:2]; higher PC bits are ignored, so addresses wrap modulo the memory size.
REQ-018 State machine states SHALL be BOOT, RUN and HALT.
- BOOT: one cycle after reset release, with if_id_valid=0 and pc held; then RUN.
- RUN: fetches.
- HALT: terminal until reset.
REQ-019 In RUN with no redirect and no stall, each edge SHALL load:
- pc <= pc+4 (32-bit wrap from FFFF_FFFC to 0);
- if_id_instruction <= imem_data;
- if_id_pc_plus4 <= pc+4;
- if_id_valid <= 1;
- fetch_count <= fetch_count+1.
REQ-020 In RUN with stall=1 and redirect_valid=0, pc, the IF/ID register, if_id_valid and fetch_count SHALL hold.
REQ-021 With redirect_valid=1 in RUN, redirect SHALL take priority over stall:
- pc <= {redirect_target[31:2],2'b00};
- if_id_valid <= 0 (flush);
- fetch_count unchanged.
REQ-022 A redirect with target[1:0]!=0 SHALL set misaligned to 1 and perform the aligned redirect of REQ-021; misaligned stays set until reset.
REQ-023 Fetch latency SHALL be exactly one cycle: the instruction at pc appears in IF/ID on the next edge.
REQ-024 When RUN fetches imem_data==32'h0000_000C (syscall), the word SHALL be loaded into IF/ID as normal, and the state SHALL then move to HALT with pc frozen at the syscall address+4.
REQ-025 In HALT, if_id_valid SHALL go 0 on the next edge unless stall=1, in which case the syscall is held until stall drops. No further fetches, redirects or count changes SHALL occur in HALT, and halted=1.
REQ-026 A redirect in the same cycle as a fetched syscall SHALL win: no halt, flush as in REQ-021.
REQ-027 fetch_count SHALL wrap from FFFF_FFFF to 0.

Reset
REQ-028 Assertion of system_reset_n=0 SHALL immediately, independent of the clock, set:
- state=BOOT, pc=RESET_PC;
- if_id_valid=0, if_id_instruction=0, if_id_pc_plus4=0;
- halted=0, misaligned=0, fetch_count=0.
REQ-029 Reset asserted mid-operation, including during stall or HALT, SHALL discard all state; fetch restarts at RESET_PC after BOOT.

Structure
REQ-030 The state encodings, RESET_PC default and the syscall opcode constant SHALL live in the shared pipeline definitions include file, guarded against double inclusion.
REQ-031 The PC register with its next-PC mux SHALL be a sub-module named program_counter; the IF/ID register, state machine and counter SHALL remain in instruction_fetch.

Verification
REQ-032 Reset, then free run with memory words 0..3 = 20080001, 20090002, 00000000, 0000000C. Required: BOOT cycle; IF/ID shows the four words with pc_plus4 = 4, 8, C, 10; halted=1; pc=10; fetch_count=4.
REQ-033 Stall held 3 cycles after the second fetch. Required: pc=8, if_id_instruction=20090002 and fetch_count=2 stable for 3 cycles, then resume.
REQ-034 redirect_valid=1 with target 0000_0040 and stall=1 in the same cycle. Required: next pc=40, if_id_valid=0, then the word at index 16 is fetched.
REQ-035 Redirect target 0000_0042. Required: pc=40 and misaligned=1, persisting after further redirects.
REQ-036 With SIZE_EXP2=4, run to pc=40. Required: imem_address=0. Separately, RESET_PC=FFFF_FFFC: next pc=0.
REQ-037 Assert reset while halted, and again while stalled. Required: all outputs at their reset values immediately, before the next edge; fetch restarts at RESET_PC.
